// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle divide controller.
package div_ctrl_pkg;

    localparam int DATA_BUS_WIDTH = 32;
    localparam int DIV_CYCLES_DEF = 32;
    // Working register: {rem[32:0], quo[31:0]}
    localparam int WORK_W = 2 * DATA_BUS_WIDTH + 1;

    typedef logic [DATA_BUS_WIDTH-1:0] data_bus_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // Two's-complement negate when en is set, pass-through otherwise.
    function automatic data_bus_t neg_if(input data_bus_t v, input logic en);
        return en ? (~v + data_bus_t'(1)) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_iter_unit.sv
// One radix-2 restoring division step: shift the working register left,
// trial-subtract the divisor from the partial remainder, keep the
// difference and set the quotient bit when it does not borrow.
module div_iter_unit
    import div_ctrl_pkg::*;
(
    input  logic [WORK_W-1:0] work_in,
    input  data_bus_t         divisor,
    output logic [WORK_W-1:0] work_out
);

    logic [WORK_W-1:0]       shifted;
    logic [DATA_BUS_WIDTH:0] diff;

    // Shift and trial subtract; diff MSB is the borrow of the 33-bit subtract.
    always_comb begin
        shifted  = work_in << 1;
        diff     = shifted[WORK_W-1:DATA_BUS_WIDTH] - {1'b0, divisor};
        work_out = shifted;
        if (!diff[DATA_BUS_WIDTH]) begin
            work_out[WORK_W-1:DATA_BUS_WIDTH] = diff;
            work_out[0]                       = 1'b1;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for the multi-cycle DIV/DIVU path.
// Build option: define DIV_SIGNED_EN to honour signed_div (abs on entry,
// sign fix-up on exit). Without it every divide is unsigned and the
// abs/negate logic is absent; cycle timing is identical either way.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      signed_div,
    input  data_bus_t dividend,
    input  data_bus_t divisor,
    input  logic      cancel,
    output logic      stall_req,
    output logic      result_ready,
    output data_bus_t quotient,
    output data_bus_t remainder
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    div_state_t        state, nstate;
    logic [CNT_W-1:0]  cnt;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] step_out;
    data_bus_t         dvs_r;
    logic              rdy_q;
    logic              accept;
    logic              last_step;
    data_bus_t         abs_dvd, abs_dvs;
    data_bus_t         q_raw, r_raw, q_fix, r_fix;
    logic              unused_top;

    assign accept    = (state == DIV_IDLE) & start & ~cancel;
    assign last_step = (cnt == CNT_W'(DIV_CYCLES - 1));

    div_iter_unit u_iter (
        .work_in (work),
        .divisor (dvs_r),
        .work_out(step_out)
    );

    assign q_raw      = step_out[DATA_BUS_WIDTH-1:0];
    assign r_raw      = step_out[2*DATA_BUS_WIDTH-1:DATA_BUS_WIDTH];
    // After a step the remainder is below the divisor, so the top bit is always 0.
    assign unused_top = step_out[WORK_W-1];

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;

    assign abs_dvd = neg_if(dividend, signed_div & dividend[DATA_BUS_WIDTH-1]);
    assign abs_dvs = neg_if(divisor,  signed_div & divisor[DATA_BUS_WIDTH-1]);
    assign q_fix   = neg_if(q_raw, neg_q);
    assign r_fix   = neg_if(r_raw, neg_r);

    // Capture the sign fix-up flags together with the operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= signed_div & (dividend[DATA_BUS_WIDTH-1] ^ divisor[DATA_BUS_WIDTH-1]);
            neg_r <= signed_div & dividend[DATA_BUS_WIDTH-1];
        end
    end
`else
    logic unused_sdiv;

    assign abs_dvd     = dividend;
    assign abs_dvs     = divisor;
    assign q_fix       = q_raw;
    assign r_fix       = r_raw;
    assign unused_sdiv = signed_div;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= nstate;
    end

    // Next-state logic; cancel kills any in-flight divide.
    always_comb begin
        nstate = state;
        case (state)
            DIV_IDLE: if (accept) nstate = (divisor == '0) ? DIV_ZERO : DIV_RUN;
            DIV_ZERO: nstate = DIV_DONE;
            DIV_RUN:  if (last_step) nstate = DIV_DONE;
            DIV_DONE: nstate = DIV_IDLE;
            default:  nstate = DIV_IDLE;
        endcase
        if (cancel && state != DIV_IDLE) nstate = DIV_IDLE;
    end

    // Stall is combinational so EX is held in the very cycle start appears;
    // it is dropped while reset is asserted.
    assign stall_req    = rst & (accept | (state == DIV_ZERO) | (state == DIV_RUN));
    // A flush arriving in the DONE cycle suppresses the strobe.
    assign result_ready = rdy_q & ~cancel;

    // Operand latch, iteration datapath and registered result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            work      <= '0;
            dvs_r     <= '0;
            rdy_q     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            rdy_q <= (nstate == DIV_DONE);
            if (accept && divisor != '0) begin
                work  <= {{(WORK_W-DATA_BUS_WIDTH){1'b0}}, abs_dvd};
                dvs_r <= abs_dvs;
                cnt   <= '0;
            end
            if (state == DIV_RUN) begin
                work <= step_out;
                cnt  <= cnt + CNT_W'(1);
            end
            if (state == DIV_ZERO && nstate == DIV_DONE) begin
                quotient  <= '0;
                remainder <= '0;
            end
            if (state == DIV_RUN && nstate == DIV_DONE) begin
                quotient  <= q_fix;
                remainder <= r_fix;
            end
        end
    end

endmodule
